// File: rtl/rv32i_fetch_pkg.sv
// Shared definitions for the RV32I instruction fetch path: state encoding,
// NOP reset word, default memory timeout and small address helpers.
package rv32i_fetch_pkg;
  localparam int XLEN                   = 32;
  localparam int BYTE_W                 = 8;
  localparam int BYTES_PER_INSTR        = XLEN / BYTE_W;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } fetch_state_e;

  typedef logic [$clog2(BYTES_PER_INSTR)-1:0] byte_idx_t;
  typedef logic [BYTES_PER_INSTR-1:0][BYTE_W-1:0] instr_bytes_t;

  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

  function automatic int tmo_ctr_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction
endpackage

// File: rtl/instr_fetch_responder_if.sv
// Byte-wide instruction memory port: the fetch responder is the master,
// the memory (or bench model) answers on the slave side.
interface instr_fetch_responder_if;
  import rv32i_fetch_pkg::*;

  logic              imem_rd;
  logic [XLEN-1:0]   imem_addr;
  logic [BYTE_W-1:0] imem_rdata;
  logic              imem_valid;

  modport master (
    output imem_rd,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_rd,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/fetch_timeout_ctr.sv
// Counts consecutive stalled read cycles; saturates instead of wrapping so a
// stuck memory can never alias back to a fresh count.
module fetch_timeout_ctr
  import rv32i_fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);
  localparam int            W    = tmo_ctr_width(TIMEOUT_CYCLES);
  localparam logic [W-1:0]  LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        cnt <= '0;
    else if (clear)                 cnt <= '0;
    else if (count && (cnt != '1))  cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == LAST);
endmodule

// File: rtl/instr_fetch_responder.sv
// Assembles a 32-bit instruction from four little-endian byte reads, with
// misalignment and memory-timeout detection and abort on request drop.
module instr_fetch_responder
  import rv32i_fetch_pkg::*;
#(
  parameter int              TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter logic [XLEN-1:0] RESET_INSTR    = NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instrfetch,
  input  logic [XLEN-1:0]          pc,
  instr_fetch_responder_if.master  imem,
  output logic [XLEN-1:0]          instr,
  output logic                     instr_fetched,
  output logic                     fetch_err
);
  fetch_state_e    state, state_n;
  logic [XLEN-1:0] base;
  byte_idx_t       byte_idx;
  instr_bytes_t    shadow, word_n;

  logic ld_base, cap, abort;
  logic ctr_clear, ctr_count, expired;
  logic last_byte;

  assign last_byte = (byte_idx == byte_idx_t'(BYTES_PER_INSTR - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // A dropped request wins over a byte arriving in the same cycle.
  always_comb begin
    state_n   = state;
    ld_base   = 1'b0;
    cap       = 1'b0;
    abort     = 1'b0;
    ctr_clear = 1'b0;
    ctr_count = 1'b0;
    unique case (state)
      IDLE: begin
        if (instrfetch) begin
          if (is_aligned(pc)) begin
            ld_base   = 1'b1;
            ctr_clear = 1'b1;
            state_n   = READ;
          end else begin
            state_n   = ERR;
          end
        end
      end
      READ: begin
        if (!instrfetch) begin
          abort     = 1'b1;
          ctr_clear = 1'b1;
          state_n   = IDLE;
        end else if (imem.imem_valid) begin
          cap       = 1'b1;
          ctr_clear = 1'b1;
          if (last_byte) state_n = DONE;
        end else begin
          ctr_count = 1'b1;
          if (expired) state_n = ERR;
        end
      end
      DONE, ERR: begin
        if (!instrfetch) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    word_n           = shadow;
    word_n[byte_idx] = imem.imem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base     <= '0;
      byte_idx <= '0;
      shadow   <= '0;
      instr    <= RESET_INSTR;
    end else begin
      if (ld_base) begin
        base     <= pc;
        byte_idx <= '0;
        shadow   <= '0;
      end
      if (abort) begin
        byte_idx <= '0;
        shadow   <= '0;
      end
      // instr is only ever written on the edge that enters DONE.
      if (cap) begin
        shadow   <= word_n;
        byte_idx <= byte_idx + 1'b1;
        if (last_byte) instr <= word_n;
      end
    end
  end

  fetch_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (ctr_clear),
    .count   (ctr_count),
    .expired (expired)
  );

  assign imem.imem_rd   = (state == READ);
  assign imem.imem_addr = base + XLEN'(byte_idx);
  assign instr_fetched  = (state == DONE);
  assign fetch_err      = (state == ERR);
endmodule

// File: tb/tb_instr_fetch_responder.sv
// Directed bench: byte-memory model with programmable wait states, a
// transaction-level fetch model compared every cycle, plus literal checks.
module tb_instr_fetch_responder;
  localparam int TMO     = 16;
  localparam int P_IDLE  = 0;
  localparam int P_BUSY  = 1;
  localparam int P_OK    = 2;
  localparam int P_BAD   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instrfetch = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr;
  logic        instr_fetched, fetch_err;

  instr_fetch_responder_if bus ();

  instr_fetch_responder dut (
    .clk           (clk),
    .rst           (rst),
    .instrfetch    (instrfetch),
    .pc            (pc),
    .imem          (bus),
    .instr         (instr),
    .instr_fetched (instr_fetched),
    .fetch_err     (fetch_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [7:0] mem [256];
  int         wcfg   = 0;
  logic       mem_on = 1'b1;
  int         wcnt   = 0;

  assign bus.imem_valid = mem_on && bus.imem_rd && (wcnt >= wcfg);
  assign bus.imem_rdata = mem[bus.imem_addr[7:0]];

  always @(posedge clk) begin
    if (rst || !bus.imem_rd || bus.imem_valid) wcnt <= 0;
    else                                       wcnt <= wcnt + 1;
  end

  // ---------------- fetch model ----------------
  logic        s_have = 1'b0, s_rst, s_fetch, s_valid;
  logic [31:0] s_pc;
  logic [7:0]  s_rdata;

  always @(posedge clk) begin
    s_have  <= 1'b1;
    s_rst   <= rst;
    s_fetch <= instrfetch;
    s_pc    <= pc;
    s_valid <= bus.imem_valid;
    s_rdata <= bus.imem_rdata;
  end

  int          m_phase = P_IDLE;
  int          m_stall = 0;
  logic [31:0] m_base  = '0;
  logic [31:0] m_instr = 32'h13;
  logic [7:0]  got [$];

  task automatic model_reset();
    m_phase = P_IDLE;
    m_stall = 0;
    m_base  = '0;
    m_instr = 32'h0000_0013;
    got.delete();
  endtask

  task automatic model_step(input logic f, input logic [31:0] a, input logic v, input logic [7:0] d);
    case (m_phase)
      P_IDLE: if (f) begin
        if (a % 4 != 0) m_phase = P_BAD;
        else begin
          m_base = a; m_stall = 0; got.delete(); m_phase = P_BUSY;
        end
      end
      P_BUSY: begin
        if (!f) begin
          got.delete(); m_phase = P_IDLE;
        end else if (v) begin
          got.push_back(d);
          m_stall = 0;
          if (got.size() == 4) begin
            m_instr = {got[3], got[2], got[1], got[0]};
            m_phase = P_OK;
          end
        end else begin
          m_stall++;
          if (m_stall == TMO) m_phase = P_BAD;
        end
      end
      default: if (!f) m_phase = P_IDLE;
    endcase
  endtask

  int          rd_cnt = 0;
  logic [31:0] addr_log [$];

  always @(negedge clk) begin
    if (rst) model_reset();
    else if (s_have && !s_rst) model_step(s_fetch, s_pc, s_valid, s_rdata);
    check("imem_rd",       32'(bus.imem_rd),    32'(m_phase == P_BUSY));
    check("instr_fetched", 32'(instr_fetched),  32'(m_phase == P_OK));
    check("fetch_err",     32'(fetch_err),      32'(m_phase == P_BAD));
    check("instr",         instr,               m_instr);
    if (m_phase == P_BUSY) check("imem_addr", bus.imem_addr, m_base + 32'(got.size()));
    if (bus.imem_rd) rd_cnt++;
    if (bus.imem_rd && bus.imem_valid) addr_log.push_back(bus.imem_addr);
  end

  // ---------------- stimulus ----------------
  task automatic go(input logic [31:0] a);
    @(negedge clk);
    #1;
    instrfetch = 1'b1;
    pc         = a;
  endtask

  task automatic wait_end(output int n);
    n = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (instr_fetched || fetch_err) begin
        n = k;
        break;
      end
    end
    if (n == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_budget: no fetched/err within 60 edges, want completion");
    end
  endtask

  task automatic drop();
    #1;
    instrfetch = 1'b0;
    @(negedge clk);
  endtask

  int n, log0, rd0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[8'h10] = 8'h93; mem[8'h11] = 8'h00; mem[8'h12] = 8'h50; mem[8'h13] = 8'h00;
    mem[8'h20] = 8'hB7; mem[8'h21] = 8'h12; mem[8'h22] = 8'h34; mem[8'h23] = 8'hAB;

    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_flags", {29'd0, bus.imem_rd, instr_fetched, fetch_err}, 32'd0);

    // zero-wait fetch
    go(32'h10);
    wait_end(n);
    check("zw_edges", n, 5);
    check("zw_instr", instr, 32'h0050_0093);
    check("zw_err",   32'(fetch_err), 32'd0);
    drop();

    // two wait cycles before each byte
    wcfg = 2;
    log0 = addr_log.size();
    go(32'h10);
    wait_end(n);
    check("ws_edges", n, 13);
    check("ws_instr", instr, 32'h0050_0093);
    check("ws_nbytes", addr_log.size() - log0, 4);
    for (int i = 0; i < 4; i++)
      if (log0 + i < addr_log.size()) check("ws_addr", addr_log[log0 + i], 32'h10 + 32'(i));
    drop();

    // misaligned pc
    rd0 = rd_cnt;
    go(32'h12);
    wait_end(n);
    check("mis_edges", n, 1);
    check("mis_err",   32'(fetch_err), 32'd1);
    check("mis_instr", instr, 32'h0050_0093);
    check("mis_no_rd", rd_cnt - rd0, 0);
    drop();
    check("mis_idle", 32'(fetch_err), 32'd0);

    // memory never answers
    mem_on = 1'b0;
    go(32'h10);
    wait_end(n);
    check("tmo_edges", n, 17);
    check("tmo_err",   32'(fetch_err), 32'd1);
    check("tmo_instr", instr, 32'h0050_0093);
    drop();
    mem_on = 1'b1;

    // abort after two bytes, then a clean fetch at 0x20
    wcfg = 0;
    go(32'h20);
    repeat (3) @(negedge clk);
    drop();
    check("abort_rd",    32'(bus.imem_rd), 32'd0);
    check("abort_instr", instr, 32'h0050_0093);
    go(32'h20);
    wait_end(n);
    check("w20_edges", n, 5);
    check("w20_instr", instr, 32'hAB34_12B7);
    drop();

    // pc changes mid-READ are ignored
    go(32'h10);
    @(negedge clk);
    #1 pc = 32'h21;
    wait_end(n);
    check("pcchg_edges", n, 4);
    check("pcchg_instr", instr, 32'h0050_0093);
    check("pcchg_err",   32'(fetch_err), 32'd0);
    drop();

    // reset in the middle of a READ
    wcfg = 2;
    go(32'h20);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("mrst_rd",    32'(bus.imem_rd), 32'd0);
    check("mrst_instr", instr, 32'h0000_0013);
    check("mrst_flags", {30'd0, instr_fetched, fetch_err}, 32'd0);
    instrfetch = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;

    // first request after reset is honoured straight away
    wcfg = 0;
    go(32'h10);
    wait_end(n);
    check("post_rst_edges", n, 5);
    check("post_rst_instr", instr, 32'h0050_0093);
    drop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
